// File: rtl/dm_responder.sv
// Data-memory responder: request/ready handshake with WAIT_CYCLES wait states, store lane steering, load extension.
// Optional feature macro: DM_MISALIGN_TRAP_EN (flags misaligned accesses on err instead of aligning them down).
module dm_responder #(
    parameter int ADDR_WIDTH  = 7,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_type,
    output logic        ready,
    output logic [31:0] rdata
`ifdef DM_MISALIGN_TRAP_EN
    ,
    output logic        err
`endif
);
    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        mem_w_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  type_q;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        in_idle, commit, mem_we;
    logic        cur_w;
    logic [31:0] cur_addr, cur_wdata, eff_addr, rd_word, wd, load_fmt;
    logic [2:0]  cur_type;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic        is_byte, is_half, is_signed, misalign;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [ADDR_WIDTH-1:0] idx;
    logic        unused_bits;

    // A zero-wait access commits on its accept edge, so the live inputs are used while IDLE.
    assign in_idle   = (state_q == IDLE);
    assign cur_w     = in_idle ? mem_w   : mem_w_q;
    assign cur_addr  = in_idle ? addr    : addr_q;
    assign cur_wdata = in_idle ? wdata   : wdata_q;
    assign cur_type  = in_idle ? dm_type : type_q;
    assign commit    = (in_idle && req && (WAIT_CYCLES == 0)) || (state_q == WAIT && cnt_q == 4'd1);
    assign mem_we    = commit && cur_w && rst_n;

    always_comb begin
        is_byte   = (cur_type == 3'b011) || (cur_type == 3'b100);
        is_half   = (cur_type == 3'b001) || (cur_type == 3'b010);
        is_signed = (cur_type == 3'b001) || (cur_type == 3'b011);
        misalign  = is_half ? cur_addr[0] : (!is_byte && cur_addr[1:0] != 2'b00);
        eff_addr  = cur_addr;
`ifndef DM_MISALIGN_TRAP_EN
        if (is_half)       eff_addr[0]   = 1'b0;
        else if (!is_byte) eff_addr[1:0] = 2'b00;
`endif
        lane = eff_addr[1:0];
        idx  = eff_addr[ADDR_WIDTH+1:2];
        if (is_byte) begin
            be = 4'b0001 << lane;
            wd = {4{cur_wdata[7:0]}};
        end else if (is_half) begin
            be = lane[1] ? 4'b1100 : 4'b0011;
            wd = {2{cur_wdata[15:0]}};
        end else begin
            be = 4'b1111;
            wd = cur_wdata;
        end
`ifdef DM_MISALIGN_TRAP_EN
        if (misalign) be = 4'b0000;
`endif
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_q [DEPTH];
            always_ff @(posedge clk) begin
                if (mem_we && be[gi]) lane_q[idx] <= wd[gi*8 +: 8];
            end
            assign rd_word[gi*8 +: 8] = lane_q[idx];
        end
    endgenerate

    always_comb begin
        sel_byte = rd_word[lane*8 +: 8];
        sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        if (is_byte)      load_fmt = {{24{is_signed & sel_byte[7]}}, sel_byte};
        else if (is_half) load_fmt = {{16{is_signed & sel_half[15]}}, sel_half};
        else              load_fmt = rd_word;
`ifdef DM_MISALIGN_TRAP_EN
        if (misalign) load_fmt = 32'h0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mem_w_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            type_q  <= 3'b000;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= commit;
            err_q   <= commit && misalign;
            if (commit && !cur_w) rdata_q <= load_fmt;
            case (state_q)
                IDLE: if (req) begin
                    mem_w_q <= mem_w;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    type_q  <= dm_type;
                    cnt_q   <= WAIT_LD;
                    state_q <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready = ready_q;
    assign rdata = rdata_q;
`ifdef DM_MISALIGN_TRAP_EN
    assign err = err_q;
    assign unused_bits = ^{cur_addr[31:ADDR_WIDTH+2]};
`else
    assign unused_bits = ^{cur_addr[31:ADDR_WIDTH+2], err_q};
`endif
endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the pipelined RISC-V core: the memory-side end of the core's DM port (write enable, address, store data, access type, load data). It adds a request/ready handshake with a configurable number of wait states. It also performs byte-lane steering for stores and sign/zero extension for loads, so the core sees fully formatted 32-bit load data. Storage is an internal word array sized by parameter.

## Interface
Parameters:
- `ADDR_WIDTH`, default 7 — word-index bits; depth = 2^ADDR_WIDTH words.
- `WAIT_CYCLES`, default 0 — wait states inserted per access (0..15).

Ports:
- `clk` — input, 1 — single clock, rising edge.
- `rst_n` — input, 1 — reset, asynchronous, active-low.
- `req` — input, 1 — access request; held high, with fields stable, until `ready`.
- `mem_w` — input, 1 — 1 = store, 0 = load.
- `addr` — input, 32 — byte address.
- `wdata` — input, 32 — store data, right-aligned.
- `dm_type` — input, 3 — access type: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; 101–111 are treated as word.
- `ready` — output, 1 — one-cycle completion pulse.
- `rdata` — output, 32 — formatted load data; valid while `ready` is high.
- `err` — output, 1 — misaligned-access flag. This port exists only with `DM_MISALIGN_TRAP_EN`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On `req`=1, latch `mem_w`, `addr`, `wdata` and `dm_type`; load the counter with `WAIT_CYCLES`.
  - Next state is WAIT if `WAIT_CYCLES`>0, else RESP.
- WAIT: decrement the counter each cycle; when the counter reaches 1, go to RESP.
- Commit happens on the edge entering RESP:
  - Stores update the array.
  - Loads capture formatted data into `rdata`.
- RESP: `ready`=1 for exactly one cycle, then unconditionally return to IDLE.
- New requests are accepted only in IDLE. A `req` still high in the cycle after `ready` starts a new transaction.
- Word index is `addr[ADDR_WIDTH+1:2]`; higher address bits are ignored, so addresses alias modulo depth.
- Stores:
  - Word: all four lanes are written.
  - Half: `wdata[15:0]` goes to lanes {1,0} if `addr[1]`=0, else lanes {3,2}.
  - Byte: `wdata[7:0]` goes to lane `addr[1:0]`.
  - Untouched lanes keep their contents.
- Loads:
  - The selected lane(s) are shifted down.
  - Signed types replicate bit 15 or bit 7 into the upper bits; unsigned types zero-fill.
- Store responses leave `rdata` at its previous value.
- The array is not reset; contents are undefined until written.
- Reset mid-transaction:
  - State goes to IDLE; a store not yet committed is discarded.
  - `ready`, `rdata`, `err` and the counter go to 0.
  - Already-committed array contents are retained.

## Timing
- Reset values: `ready`=0, `rdata`=32'h0, `err`=0, state IDLE, counter 0.
- Latency: with `req` sampled high at edge N, `ready` is high in cycle N+1+`WAIT_CYCLES`.
- Minimum request-to-request spacing is `WAIT_CYCLES`+2 cycles (IDLE→…→RESP→IDLE).
- Store data is visible to any later transaction: a load issued right after a store's `ready` returns the new data.
- `req` deasserted during WAIT is ignored; the latched transaction completes.
- `ready` is registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `DM_MISALIGN_TRAP_EN`. Misaligned means: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- Defined:
  - Misaligned accesses complete with normal latency and with `err`=1 alongside `ready`.
  - A misaligned store writes nothing; a misaligned load returns `rdata`=0.
  - `err` is 0 on aligned accesses.
- Undefined:
  - The `err` port is absent.
  - Misaligned addresses are aligned down (half clears `addr[0]`, word clears `addr[1:0]`) and the access proceeds normally.

## Test plan
- Reset/word: after `rst_n` release, `ready`/`rdata`=0. Store word 32'hDEADBEEF @0x10, then load word @0x10 → `rdata`=32'hDEADBEEF with `ready` one cycle after `req` (`WAIT_CYCLES`=0).
- Lanes/extension:
  - Store word 0 @0x20, then store byte 8'h80 @0x23.
  - Load byte @0x23 → 32'hFFFFFF80; load byte-unsigned → 32'h00000080.
  - Store half 16'h8001 @0x20, then load word → 32'h80008001; load half-unsigned @0x20 → 32'h00008001.
- Wait states: `WAIT_CYCLES`=3; `req` at edge N → `ready` high in cycle N+4 only. Dropping `req` in cycle N+2 still completes the access.
- Aliasing: `ADDR_WIDTH`=7; store word 32'h12345678 @0x000 → load word @0x200 returns 32'h12345678.
- Reset mid-op: `WAIT_CYCLES`=3; store 32'hFFFFFFFF @0x30 (prior contents 32'h0); assert `rst_n` low in the WAIT state → no `ready`. A later load @0x30 returns 32'h0.
- Misalignment: with `DM_MISALIGN_TRAP_EN`, store word @0x41 → `err`=1 and memory unchanged. Without it, the same store writes word @0x40.
